// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
//   Raster timing generator for the video output path (640x480 @ 60 Hz class).
//   Free-runs on the pixel clock, one pixel per clock, and produces the sync
//   pulses, the blanking flag and the current pixel coordinates. Every output
//   is registered, and all outputs describe the same pixel on every clock.
//
// Ports
//   clk        in   1   pixel clock, rising edge
//   reset      in   1   synchronous, active-high reset
//   vga_hsync  out  1   horizontal sync, active level = HSYNC_POL
//   vga_vsync  out  1   vertical sync, active level = VSYNC_POL
//   vga_blank  out  1   1 = outside the visible area
//   h_pos      out  10  current column, 0..H_TOTAL-1
//   v_pos      out  10  current line, 0..V_TOTAL-1
//
// H_TOTAL and V_TOTAL must both be <= 1024 so the coordinates fit in 10 bits.
// ----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    output logic       vga_hsync,
    output logic       vga_vsync,
    output logic       vga_blank,
    output logic [9:0] h_pos,
    output logic [9:0] v_pos
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    // Low during reset and for the first edge after it, so that pixel (0,0)
    // is presented (unblanked) for exactly one clock before counting starts.
    logic       running;
    logic [9:0] h_next;
    logic [9:0] v_next;

    // Coordinates of the pixel that the next edge will present. The outputs
    // are all derived from these so they stay aligned with h_pos/v_pos.
    always_comb begin
        h_next = h_pos;
        v_next = v_pos;
        if (!running) begin
            h_next = 10'd0;
            v_next = 10'd0;
        end else if (h_pos == H_LAST) begin
            h_next = 10'd0;
            if (v_pos == V_LAST) begin
                v_next = 10'd0;
            end else begin
                v_next = v_pos + 10'd1;
            end
        end else begin
            h_next = h_pos + 10'd1;
        end
    end

    // Registered coordinates, blanking and syncs. Vsync is decoded from
    // v_next, so it changes on the same edge that h_pos wraps to 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            running   <= 1'b0;
            h_pos     <= 10'd0;
            v_pos     <= 10'd0;
            vga_blank <= 1'b1;
            vga_hsync <= ~HSYNC_POL;
            vga_vsync <= ~VSYNC_POL;
        end else begin
            running   <= 1'b1;
            h_pos     <= h_next;
            v_pos     <= v_next;
            vga_blank <= (h_next >= H_VIS) || (v_next >= V_VIS);
            vga_hsync <= ((h_next >= HS_START) && (h_next < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
            vga_vsync <= ((v_next >= VS_START) && (v_next < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_gen
//   Bench for vga_timing_gen. Two instances share clock and reset: one with
//   the default 640x480 timing and active-low syncs, one with a tiny raster
//   and active-high syncs so whole frames (wrap, vsync window, vsync period)
//   fit in a short run. The reference model derives every expected output
//   from the number of clocks elapsed since reset release.
// ----------------------------------------------------------------------------
module tb_vga_timing_gen;

    // Default raster
    localparam int D_HV = 640, D_HF = 16, D_HS = 96, D_HB = 48;
    localparam int D_VV = 480, D_VF = 10, D_VS = 2,  D_VB = 33;
    localparam int D_HT = D_HV + D_HF + D_HS + D_HB;

    // Small raster, active-high syncs
    localparam int S_HV = 20, S_HF = 4, S_HS = 6, S_HB = 5;
    localparam int S_VV = 12, S_VF = 2, S_VS = 2, S_VB = 3;
    localparam int S_HT = S_HV + S_HF + S_HS + S_HB;
    localparam int S_VT = S_VV + S_VF + S_VS + S_VB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic       d_hsync, d_vsync, d_blank;
    logic [9:0] d_h, d_v;
    logic       s_hsync, s_vsync, s_blank;
    logic [9:0] s_h, s_v;

    int checks = 0;
    int failures = 0;

    // Clocks elapsed since the first post-reset edge; -1 while in reset.
    longint d_n = -1;
    longint s_n = -1;

    // Sync pulse run-length and vsync period tracking.
    int     d_hs_run = 0;
    int     s_vs_run = 0;
    longint s_vs_last_start = -1;

    always #20 clk = ~clk;

    vga_timing_gen dut_default (
        .clk       (clk),
        .reset     (reset),
        .vga_hsync (d_hsync),
        .vga_vsync (d_vsync),
        .vga_blank (d_blank),
        .h_pos     (d_h),
        .v_pos     (d_v)
    );

    vga_timing_gen #(
        .H_VISIBLE (S_HV), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
        .V_VISIBLE (S_VV), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB),
        .HSYNC_POL (1'b1), .VSYNC_POL (1'b1)
    ) dut_small (
        .clk       (clk),
        .reset     (reset),
        .vga_hsync (s_hsync),
        .vga_vsync (s_vsync),
        .vga_blank (s_blank),
        .h_pos     (s_h),
        .v_pos     (s_v)
    );

    // Raster rules evaluated directly from the elapsed clock count.
    function automatic void model(input longint n,
                                  input int hv, input int hf, input int hs, input int hb,
                                  input int vv, input int vf, input int vs, input int vb,
                                  input bit hp, input bit vp,
                                  output logic [9:0] eh, output logic [9:0] ev,
                                  output logic eb, output logic ehs, output logic evs);
        int ht, vt, x, y;
        ht = hv + hf + hs + hb;
        vt = vv + vf + vs + vb;
        if (n < 0) begin
            eh = 10'd0; ev = 10'd0; eb = 1'b1; ehs = ~hp; evs = ~vp;
        end else begin
            x   = int'(n % longint'(ht));
            y   = int'((n / longint'(ht)) % longint'(vt));
            eh  = 10'(x);
            ev  = 10'(y);
            eb  = (x >= hv) || (y >= vv);
            ehs = (x >= hv + hf && x < hv + hf + hs) ? hp : ~hp;
            evs = (y >= vv + vf && y < vv + vf + vs) ? vp : ~vp;
        end
    endfunction

    task automatic checkField(input string tag, input logic [9:0] got, input logic [9:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("[TB] FAIL %s got=%0d expected=%0d (d_n=%0d s_n=%0d)", tag, got, exp, d_n, s_n);
        end
    endtask

    task automatic checkOutput();
        logic [9:0] eh, ev;
        logic       eb, ehs, evs;

        model(d_n, D_HV, D_HF, D_HS, D_HB, D_VV, D_VF, D_VS, D_VB, 1'b0, 1'b0, eh, ev, eb, ehs, evs);
        checkField("d_h_pos", d_h, eh);
        checkField("d_v_pos", d_v, ev);
        checkField("d_blank", {9'd0, d_blank}, {9'd0, eb});
        checkField("d_hsync", {9'd0, d_hsync}, {9'd0, ehs});
        checkField("d_vsync", {9'd0, d_vsync}, {9'd0, evs});

        model(s_n, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB, 1'b1, 1'b1, eh, ev, eb, ehs, evs);
        checkField("s_h_pos", s_h, eh);
        checkField("s_v_pos", s_v, ev);
        checkField("s_blank", {9'd0, s_blank}, {9'd0, eb});
        checkField("s_hsync", {9'd0, s_hsync}, {9'd0, ehs});
        checkField("s_vsync", {9'd0, s_vsync}, {9'd0, evs});

        // Pulse widths and vsync period; pulses cut short by reset are discarded.
        if (d_n < 0) begin
            d_hs_run = 0;
            s_vs_run = 0;
            s_vs_last_start = -1;
        end else begin
            if (d_hsync === 1'b0) begin
                d_hs_run++;
            end else if (d_hs_run != 0) begin
                checkField("d_hsync_width", 10'(d_hs_run), 10'(D_HS));
                d_hs_run = 0;
            end
            if (s_vsync === 1'b1) begin
                if (s_vs_run == 0) begin
                    if (s_vs_last_start >= 0) begin
                        checkField("s_vsync_period", 10'(s_n - s_vs_last_start), 10'(S_HT * S_VT));
                    end
                    s_vs_last_start = s_n;
                end
                s_vs_run++;
            end else if (s_vs_run != 0) begin
                checkField("s_vsync_width", 10'(s_vs_run), 10'(S_VS * S_HT));
                s_vs_run = 0;
            end
        end
    endtask

    // Drive reset for a number of clocks, advance the model, check after each edge.
    task automatic applyStimulus(input bit r, input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            reset = r;
            @(posedge clk);
            d_n = r ? -1 : d_n + 1;
            s_n = r ? -1 : s_n + 1;
            #1;
            checkOutput();
        end
    endtask

    initial begin
        int run_len;
        int rst_len;

        $display("[TB] start");

        // Reset held for 3 clocks: origin, blanked, syncs idle.
        applyStimulus(1'b1, 3);
        checkField("rst_d_blank", {9'd0, d_blank}, 10'd1);
        checkField("rst_d_hsync", {9'd0, d_hsync}, 10'd1);
        checkField("rst_s_vsync", {9'd0, s_vsync}, 10'd0);

        // First clock after release presents (0,0) unblanked.
        applyStimulus(1'b0, 1);
        checkField("rel_d_h", d_h, 10'd0);
        checkField("rel_d_blank", {9'd0, d_blank}, 10'd0);

        // Run to column 300 of line 2, crossing two line wraps on the way.
        applyStimulus(1'b0, 2 * D_HT + 300);
        checkField("mid_d_h", d_h, 10'd300);
        checkField("mid_d_v", d_v, 10'd2);

        // One-clock mid-frame reset, then release and resume.
        applyStimulus(1'b1, 1);
        checkField("midrst_blank", {9'd0, d_blank}, 10'd1);
        applyStimulus(1'b0, 1);
        checkField("midrel_blank", {9'd0, d_blank}, 10'd0);
        checkField("midrel_h", d_h, 10'd0);

        // Several full small-raster frames and a few default lines.
        applyStimulus(1'b0, 3000);

        // Random run lengths with occasional random-length resets.
        for (int i = 0; i < 20; i++) begin
            run_len = int'($urandom_range(50, 1500));
            applyStimulus(1'b0, run_len);
            if ($urandom_range(0, 3) == 0) begin
                rst_len = int'($urandom_range(1, 3));
                applyStimulus(1'b1, rst_len);
            end
        end
        applyStimulus(1'b0, 800);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
